// File: rtl/glip_uart_tx_scheduler_if.sv
// Handshake bundle between the egress FIFO / credit source, the scheduler
// and the UART transmitter. The scheduler takes the master view.
interface glip_uart_tx_scheduler_if #(
  parameter int CREDIT_WIDTH = 15
);
  logic [7:0]              in_data;
  logic                    in_valid;
  logic                    in_ready;
  logic                    credit_req;
  logic [CREDIT_WIDTH-1:0] credit_val;
  logic                    credit_ack;
  logic                    uart_cts_n;
  logic [7:0]              tx_data;
  logic                    tx_enable;
  logic                    tx_done;

  modport master (
    input  in_data, in_valid, credit_req, credit_val, uart_cts_n, tx_done,
    output in_ready, credit_ack, tx_data, tx_enable
  );

  modport slave (
    output in_data, in_valid, credit_req, credit_val, uart_cts_n, tx_done,
    input  in_ready, credit_ack, tx_data, tx_enable
  );
endinterface

// File: rtl/glip_uart_tx_scheduler.sv
// GLIP UART transmit scheduler: interleaves escaped data bytes and 3-byte
// credit messages (ESC, credit[14:8], credit[7:0]) onto a UART transmitter.
// Messages are atomic and arbitrated round-robin between data and credit.
// Optional byte statistics counter: define GLIP_UART_TX_STATS_EN.
module glip_uart_tx_scheduler #(
  parameter int         CREDIT_WIDTH = 15,
  parameter logic [7:0] ESC          = 8'hFE
) (
  input  logic                     clk,
  input  logic                     rst_n,
  glip_uart_tx_scheduler_if.master bus,
  output logic                     error,
  output logic [31:0]              tx_byte_count
);

  typedef enum logic [2:0] {
    IDLE,
    DATA_ESC,
    DATA,
    CRED_ESC,
    CRED_HI,
    CRED_LO
  } state_t;

  state_t                  state, state_nxt;
  logic                    last_grant, last_grant_nxt;
  logic [CREDIT_WIDTH-1:0] cred_q;
  logic                    grant_credit;

  // Next-state, arbitration and output decode
  always_comb begin
    state_nxt      = state;
    last_grant_nxt = last_grant;
    bus.in_ready   = 1'b0;
    bus.credit_ack = 1'b0;
    bus.tx_enable  = 1'b0;
    bus.tx_data    = '0;
    // Credit wins when it is the only requester, or when both request and
    // data was served last.
    grant_credit   = bus.credit_req && (!bus.in_valid || !last_grant);
    case (state)
      IDLE: begin
        if (rst_n && !bus.uart_cts_n) begin
          if (grant_credit) begin
            bus.credit_ack = 1'b1;
            last_grant_nxt = 1'b1;
            state_nxt      = CRED_ESC;
          end else if (bus.in_valid) begin
            last_grant_nxt = 1'b0;
            state_nxt      = (bus.in_data == ESC) ? DATA_ESC : DATA;
          end
        end
      end
      DATA_ESC: begin
        bus.tx_enable = !bus.uart_cts_n;
        bus.tx_data   = ESC;
        if (bus.tx_done) state_nxt = DATA;
      end
      DATA: begin
        bus.tx_enable = !bus.uart_cts_n;
        bus.tx_data   = bus.in_data;
        if (bus.tx_done) begin
          bus.in_ready = 1'b1;
          state_nxt    = IDLE;
        end
      end
      CRED_ESC: begin
        bus.tx_enable = !bus.uart_cts_n;
        bus.tx_data   = ESC;
        if (bus.tx_done) state_nxt = CRED_HI;
      end
      CRED_HI: begin
        bus.tx_enable = !bus.uart_cts_n;
        bus.tx_data   = {1'b0, cred_q[14:8]};
        if (bus.tx_done) state_nxt = CRED_LO;
      end
      CRED_LO: begin
        bus.tx_enable = !bus.uart_cts_n;
        bus.tx_data   = cred_q[7:0];
        if (bus.tx_done) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, round-robin pointer and captured credit value
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      last_grant <= 1'b0;
      cred_q     <= '0;
    end else begin
      state      <= state_nxt;
      last_grant <= last_grant_nxt;
      if (bus.credit_ack) cred_q <= bus.credit_val;
    end
  end

  // Sticky error: transmitter reported completion with nothing in flight
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      error <= 1'b0;
    end else if (state == IDLE && bus.tx_done) begin
      error <= 1'b1;
    end
  end

`ifdef GLIP_UART_TX_STATS_EN
  // Count every completed byte of a message; wraps naturally
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_byte_count <= '0;
    end else if (state != IDLE && bus.tx_done) begin
      tx_byte_count <= tx_byte_count + 32'd1;
    end
  end
`else
  assign tx_byte_count = '0;
`endif

endmodule

// File: tb/tb_glip_uart_tx_scheduler.sv
// Testbench for glip_uart_tx_scheduler: a message-queue reference model is
// compared against the DUT every cycle; directed scenarios add literal byte
// stream, handshake-count and error/statistics expectations.
module tb_glip_uart_tx_scheduler;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        error;
  logic [31:0] tx_byte_count;

  glip_uart_tx_scheduler_if #(.CREDIT_WIDTH(15)) bus ();

  glip_uart_tx_scheduler #(.CREDIT_WIDTH(15), .ESC(8'hFE)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus),
    .error         (error),
    .tx_byte_count (tx_byte_count)
  );

  always #5 clk = ~clk;

  int         checks = 0;
  int         failures = 0;
  logic [7:0] log_q[$];
  int         pop_cnt = 0;
  int         ack_cnt = 0;
  int         inject_req = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Reference model: a message is a queue of bytes; empty queue means idle.
  initial begin : compare
    logic [7:0]  mq[$];
    bit          m_data;
    bit          m_last;
    bit          m_err;
    logic [31:0] m_cnt;
    bit          busy;
    bit          pick_c;
    logic        e_en, e_rdy, e_ack;
    logic [7:0]  e_data;
    m_data = 0; m_last = 0; m_err = 0; m_cnt = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mq.delete();
        m_last = 0; m_err = 0; m_cnt = '0;
        chk("rst_tx_enable", bus.tx_enable, 0);
        chk("rst_tx_data", bus.tx_data, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_credit_ack", bus.credit_ack, 0);
        chk("rst_error", error, 0);
        chk("rst_byte_count", tx_byte_count, 0);
      end else begin
        busy   = (mq.size() != 0);
        e_en   = busy && !bus.uart_cts_n;
        e_data = busy ? mq[0] : 8'h00;
        e_rdy  = busy && bus.tx_done && m_data && (mq.size() == 1);
        e_ack  = 0;
        pick_c = 0;
        if (!busy && !bus.uart_cts_n && (bus.in_valid || bus.credit_req)) begin
          // both pending: serve whichever was not served last
          pick_c = bus.credit_req && !(bus.in_valid && m_last);
          e_ack  = pick_c;
        end
        chk("tx_enable", bus.tx_enable, e_en);
        chk("tx_data", bus.tx_data, e_data);
        chk("in_ready", bus.in_ready, e_rdy);
        chk("credit_ack", bus.credit_ack, e_ack);
        chk("error", error, m_err);
`ifdef GLIP_UART_TX_STATS_EN
        chk("byte_count", tx_byte_count, m_cnt);
`else
        chk("byte_count", tx_byte_count, 0);
`endif
        if (busy && bus.tx_done) begin
          void'(mq.pop_front());
          m_cnt = m_cnt + 1;
        end
        if (!busy && bus.tx_done) m_err = 1;
        if (!busy && !bus.uart_cts_n && (bus.in_valid || bus.credit_req)) begin
          if (pick_c) begin
            mq.push_back(8'hFE);
            mq.push_back({1'b0, bus.credit_val[14:8]});
            mq.push_back(bus.credit_val[7:0]);
            m_data = 0;
            m_last = 1;
          end else begin
            if (bus.in_data == 8'hFE) mq.push_back(8'hFE);
            mq.push_back(bus.in_data);
            m_data = 1;
            m_last = 0;
          end
        end
      end
    end
  end

  // UART transmitter stand-in: completes a byte after 3 enabled cycles,
  // logs what was on tx_data at completion, and counts handshakes.
  initial begin : uart_sink
    int   run;
    int   seen;
    logic nd;
    run = 0; seen = 0;
    bus.tx_done = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) pop_cnt++;
      if (bus.credit_ack) ack_cnt++;
      nd = 1'b0;
      if (bus.tx_done) begin
        log_q.push_back(bus.tx_data);
        run = 0;
      end else if (seen != inject_req) begin
        seen = inject_req;
        nd   = 1'b1;
      end else if (bus.tx_enable) begin
        run++;
        if (run >= 3) begin
          nd  = 1'b1;
          run = 0;
        end
      end
      @(posedge clk);
      #1;
      bus.tx_done = nd;
    end
  end

  task automatic wait_log(input int n, input string name);
    int b = 0;
    while (log_q.size() < n && b < 300) begin tick(1); b++; end
    checks++;
    if (log_q.size() < n) begin
      failures++;
      $display("FAIL %s timeout: bytes=%0d need=%0d", name, log_q.size(), n);
    end
  endtask

  task automatic wait_pop(input int n, input string name);
    int b = 0;
    while (pop_cnt < n && b < 300) begin tick(1); b++; end
    checks++;
    if (pop_cnt < n) begin
      failures++;
      $display("FAIL %s timeout: pops=%0d need=%0d", name, pop_cnt, n);
    end
  endtask

  task automatic wait_ack(input int n, input string name);
    int b = 0;
    while (ack_cnt < n && b < 300) begin tick(1); b++; end
    checks++;
    if (ack_cnt < n) begin
      failures++;
      $display("FAIL %s timeout: acks=%0d need=%0d", name, ack_cnt, n);
    end
  endtask

  // exp holds n bytes, first transmitted byte most significant
  task automatic check_log(input string name, input int n, input logic [63:0] exp);
    chk({name, "_len"}, log_q.size(), n);
    for (int i = 0; i < n && i < log_q.size(); i++)
      chk(name, {24'h0, log_q[i]}, {24'h0, exp[8*(n-1-i) +: 8]});
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(1);
  endtask

  initial begin : main
    int base;
    rst_n = 1'b0;
    bus.in_data = 8'h00; bus.in_valid = 1'b0;
    bus.credit_req = 1'b0; bus.credit_val = '0;
    bus.uart_cts_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    chk("post_reset_enable", bus.tx_enable, 0);
    chk("post_reset_error", error, 0);

    // plain data byte
    log_q.delete(); base = pop_cnt;
    bus.in_data = 8'h41; bus.in_valid = 1'b1;
    wait_pop(base + 1, "data41_pop");
    bus.in_valid = 1'b0;
    tick(4);
    check_log("data41", 1, 64'h41);
    chk("data41_pops", pop_cnt, base + 1);

    // escaped data byte: pop only after the second byte
    log_q.delete(); base = pop_cnt;
    bus.in_data = 8'hFE; bus.in_valid = 1'b1;
    wait_log(1, "dataFE_first");
    chk("dataFE_no_early_pop", pop_cnt, base);
    wait_pop(base + 1, "dataFE_pop");
    bus.in_valid = 1'b0;
    tick(4);
    check_log("dataFE", 2, 64'hFEFE);

    // credit message, value changed after ack
    log_q.delete(); base = ack_cnt;
    bus.credit_val = 15'h1234; bus.credit_req = 1'b1;
    wait_ack(base + 1, "cred_ack");
    bus.credit_req = 1'b0; bus.credit_val = '0;
    wait_log(3, "cred_bytes");
    tick(3);
    check_log("cred1234", 3, 64'hFE1234);
    chk("cred_acks", ack_cnt, base + 1);

    // round robin from reset with both requesters pending
    do_reset();
    log_q.delete();
    bus.in_data = 8'h41; bus.in_valid = 1'b1;
    bus.credit_val = 15'h1234; bus.credit_req = 1'b1;
    wait_log(8, "rr_bytes");
    bus.in_valid = 1'b0; bus.credit_req = 1'b0;
    tick(4);
    check_log("rr_order", 8, 64'hFE123441FE123441);

    // clear-to-send gating in IDLE and mid-message
    log_q.delete(); base = ack_cnt;
    bus.uart_cts_n = 1'b1;
    bus.in_data = 8'h41; bus.in_valid = 1'b1; bus.credit_req = 1'b1;
    tick(5);
    chk("cts_idle_bytes", log_q.size(), 0);
    chk("cts_idle_acks", ack_cnt, base);
    chk("cts_idle_enable", bus.tx_enable, 0);
    bus.in_valid = 1'b0; bus.uart_cts_n = 1'b0;
    wait_ack(base + 1, "cts_ack");
    bus.credit_req = 1'b0;
    wait_log(1, "cts_first");
    bus.uart_cts_n = 1'b1;
    tick(6);
    chk("cts_pause_bytes", log_q.size(), 1);
    chk("cts_pause_enable", bus.tx_enable, 0);
    chk("cts_pause_data", bus.tx_data, 8'h12);
    bus.uart_cts_n = 1'b0;
    wait_log(3, "cts_resume");
    tick(3);
    check_log("cts_msg", 3, 64'hFE1234);

    // reset in the middle of a credit message and of a data message
    log_q.delete(); base = ack_cnt;
    bus.credit_val = 15'h0055; bus.credit_req = 1'b1;
    wait_ack(base + 1, "abort_cred_ack");
    bus.credit_req = 1'b0;
    wait_log(1, "abort_cred_first");
    do_reset();
    tick(10);
    chk("abort_cred_bytes", log_q.size(), 1);
    chk("abort_cred_acks", ack_cnt, base + 1);
    base = pop_cnt;
    bus.in_data = 8'h41; bus.in_valid = 1'b1;
    tick(2);
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(10);
    chk("abort_data_pops", pop_cnt, base);

    // tx_done while idle raises sticky error; reset clears it
    inject_req++;
    tick(3);
    chk("err_set", error, 1);
    tick(5);
    chk("err_hold", error, 1);
    do_reset();
    chk("err_clear", error, 0);

    // byte statistics over data 41, data FE, credit
    log_q.delete(); base = pop_cnt;
    bus.in_data = 8'h41; bus.in_valid = 1'b1;
    wait_pop(base + 1, "stats_d1");
    bus.in_data = 8'hFE;
    wait_pop(base + 2, "stats_d2");
    bus.in_valid = 1'b0;
    base = ack_cnt;
    bus.credit_val = 15'h0001; bus.credit_req = 1'b1;
    wait_ack(base + 1, "stats_ack");
    bus.credit_req = 1'b0;
    wait_log(6, "stats_bytes");
    tick(3);
    check_log("stats_stream", 6, 64'h41FEFEFE0001);
`ifdef GLIP_UART_TX_STATS_EN
    chk("stats_count", tx_byte_count, 32'd6);
`else
    chk("stats_count", tx_byte_count, 32'd0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
